// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES stream arbiter.
package aes_arb_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned REQ_ID_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // First set bit strictly after ptr, wrapping over MAX_REQ; unused requester slots are zero.
  function automatic logic [REQ_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [REQ_ID_W-1:0] ptr);
    logic [REQ_ID_W-1:0] idx;
    logic                found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = ptr + REQ_ID_W'(k);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/aes_arb_route_fifo.sv
// Route FIFO: owner index of every packet forwarded into the core, popped as its response completes.
module aes_arb_route_fifo
  import aes_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [REQ_ID_W-1:0] i_push_id,
  input  logic                i_pop,
  output logic                o_full,
  output logic                o_empty,
  output logic [REQ_ID_W-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [REQ_ID_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_id;
  end

endmodule

// File: rtl/aes_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AES stream core; responses are steered back by a route FIFO.
// Optional ARB_STATS_EN adds per-requester packet counters (pkt_cnt) and a blocked-arbitration counter (stall_cnt).
module aes_stream_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_W-1:0]     s_req_tdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   s_req_tkeep,
  input  logic [NUM_REQ-1:0]            s_req_tlast,
  input  logic [NUM_REQ-1:0]            s_req_tvalid,
  output logic [NUM_REQ-1:0]            s_req_tready,
  output logic [DATA_W-1:0]             m_aes_tdata,
  output logic [DATA_W/8-1:0]           m_aes_tkeep,
  output logic                          m_aes_tlast,
  output logic                          m_aes_tvalid,
  input  logic                          m_aes_tready,
  input  logic [DATA_W-1:0]             s_aes_tdata,
  input  logic [DATA_W/8-1:0]           s_aes_tkeep,
  input  logic                          s_aes_tlast,
  input  logic                          s_aes_tvalid,
  output logic                          s_aes_tready,
  output logic [NUM_REQ*DATA_W-1:0]     m_rsp_tdata,
  output logic [NUM_REQ*DATA_W/8-1:0]   m_rsp_tkeep,
  output logic [NUM_REQ-1:0]            m_rsp_tlast,
  output logic [NUM_REQ-1:0]            m_rsp_tvalid,
  input  logic [NUM_REQ-1:0]            m_rsp_tready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_orphan
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         pkt_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int unsigned KEEP_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [REQ_ID_W-1:0] r_owner;
  logic [REQ_ID_W-1:0] w_owner_nxt;
  logic [REQ_ID_W-1:0] r_rr_ptr;
  logic [REQ_ID_W-1:0] w_rr_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  w_grant_nxt;
  logic [REQ_ID_W-1:0] w_pick;
  logic                w_push;
  logic                w_pop;
  logic                w_fwd_last;
  logic                w_full;
  logic                w_empty;
  logic [REQ_ID_W-1:0] w_head;
  logic                r_err_orphan;

  assign w_pick     = rr_pick(MAX_REQ'(s_req_tvalid), r_rr_ptr);
  assign w_fwd_last = m_aes_tvalid & m_aes_tready & m_aes_tlast;
  assign w_pop      = s_aes_tvalid & s_aes_tready & s_aes_tlast;
  assign grant      = r_grant;
  assign busy       = (r_state == ARB_GRANT) | ~w_empty;
  assign err_orphan = r_err_orphan;

  aes_arb_route_fifo #(
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (w_pick),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= REQ_ID_W'(NUM_REQ - 1);
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  // Grant is taken only with route FIFO room and released on the owner's tlast handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_grant_nxt = r_grant;
    w_push      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if ((|s_req_tvalid) && !w_full) begin
          w_push      = 1'b1;
          w_owner_nxt = w_pick;
          w_grant_nxt = NUM_REQ'(1) << w_pick;
          w_state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (w_fwd_last) begin
          w_rr_nxt    = r_owner;
          w_grant_nxt = '0;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Forward path: zero-latency pass-through from the owner to the core.
  always_comb begin
    m_aes_tdata  = '0;
    m_aes_tkeep  = '0;
    m_aes_tlast  = 1'b0;
    m_aes_tvalid = 1'b0;
    s_req_tready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if ((r_state == ARB_GRANT) && (r_owner == REQ_ID_W'(i))) begin
        m_aes_tdata     = s_req_tdata[i*DATA_W +: DATA_W];
        m_aes_tkeep     = s_req_tkeep[i*KEEP_W +: KEEP_W];
        m_aes_tlast     = s_req_tlast[i];
        m_aes_tvalid    = s_req_tvalid[i];
        s_req_tready[i] = m_aes_tready;
      end
    end
  end

  // Return path: payload is broadcast, only the route FIFO head sees valid.
  assign m_rsp_tdata = {NUM_REQ{s_aes_tdata}};
  assign m_rsp_tkeep = {NUM_REQ{s_aes_tkeep}};
  assign m_rsp_tlast = {NUM_REQ{s_aes_tlast}};

  always_comb begin
    m_rsp_tvalid = '0;
    s_aes_tready = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_empty && (w_head == REQ_ID_W'(i))) begin
        m_rsp_tvalid[i] = s_aes_tvalid;
        s_aes_tready    = m_rsp_tready[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_orphan <= 1'b0;
    end else if (s_aes_tvalid && w_empty) begin
      r_err_orphan <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_pkt_cnt [NUM_REQ];
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_pkt_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_push && (w_pick == REQ_ID_W'(i))) r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
      end
      if ((r_state == ARB_IDLE) && (|s_req_tvalid) && w_full && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) pkt_cnt[i*16 +: 16] = r_pkt_cnt[i];
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
